// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, the
// canonical NOP encoding and the default reset vector.
package if_stage_pkg;

    localparam int unsigned IF_ADDR_WIDTH = 32;
    localparam int unsigned IF_DATA_WIDTH = 32;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {address, instruction} pairs.
// clear outranks push/pop; an empty-FIFO push is poppable only next cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_count;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign full_o  = (w_count == (AW + 1)'(DEPTH));
    assign empty_o = (w_count == '0);
    assign count_o = w_count;
    assign rdata_o = r_mem[r_rptr[AW-1:0]];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i && !rst_i) begin
            r_mem[r_wptr[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: owns the PC, issues credit-limited requests
// to instruction memory, discards wrong-path responses and feeds decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = IF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH      = IF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(IF_RESET_PC),
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW  = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] NOP_W   = DATA_WIDTH'(NOP_INSN);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A  = ADDR_WIDTH'(ZERO_WORD);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_discard;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_inst_addr;

    logic [CW-1:0]         w_live;
    logic [FCW-1:0]        w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_req;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic [EW-1:0]         w_push_data;
    logic [EW-1:0]         w_head;

    assign w_jump_target = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_live        = r_cnt - r_discard;

    // Credits count in-flight live words plus buffered words, so an accepted
    // response always finds a free FIFO slot; pops this cycle earn nothing.
    assign w_req = !rst_i && !jump_i
                && (r_cnt < CW'(MAX_OUTSTANDING))
                && ((w_live + CW'(w_fifo_count)) < CW'(FIFO_DEPTH));

    assign w_fire   = w_req && imem_gnt_i;
    assign w_accept = imem_rvalid_i && (r_discard == '0) && !jump_i;
    assign w_drop   = imem_rvalid_i && (r_discard != '0);
    assign w_pop    = !rst_i && !jump_i && !stall_i && !w_fifo_empty;

    assign w_push_data = {r_resp_pc, imem_rdata_i};

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_accept),
        .pop_i   (w_pop),
        .clear_i (jump_i),
        .wdata_i (w_push_data),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
        end else if (jump_i) begin
            r_pc      <= w_jump_target;
            r_resp_pc <= w_jump_target;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (w_accept) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

    // Everything still in flight at a redirect belongs to the old path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_discard <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_fire) - CW'(imem_rvalid_i);
            if (jump_i) begin
                r_discard <= r_cnt - CW'(imem_rvalid_i);
            end else if (w_drop) begin
                r_discard <= r_discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || jump_i) begin
            r_inst      <= NOP_W;
            r_inst_addr <= ZERO_A;
        end else if (!stall_i) begin
            if (w_pop) begin
                r_inst      <= w_head[DATA_WIDTH-1:0];
                r_inst_addr <= w_head[EW-1:DATA_WIDTH];
            end else begin
                r_inst      <= NOP_W;
                r_inst_addr <= ZERO_A;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_accept && w_fifo_full));
            assert (r_cnt <= CW'(MAX_OUTSTANDING));
            assert (r_discard <= r_cnt);
            assert (!(imem_rvalid_i && (r_cnt == '0)));
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: in-order memory model plus a path/epoch
// reference model of which words decode must see and when.
module tb_if_stage;

    localparam int unsigned MAX   = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    if_stage #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } fl_t;

    fl_t         infl[$];
    logic [31:0] ready[$];
    int unsigned m_epoch = 0;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_inst = NOP;
    logic [31:0] m_iaddr = '0;
    logic [31:0] key = '0;
    int          gnt_mode = 1;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    logic        exp_req, obs_req;
    logic [31:0] exp_addr, obs_addr;
    int          n_total = 0;
    int          n_pass = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ key;
    endfunction

    // One clock: drive memory, settle, predict request, advance model, edge.
    task automatic cycle();
        int unsigned live;
        int unsigned due;
        fl_t         e;
        logic        acc;
        logic [31:0] a;
        imem_gnt_i = (gnt_mode == 2) ? ($urandom_range(0, 3) != 0) : (gnt_mode == 1);
        if (infl.size() > 0 && infl[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word(infl[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        live = 0;
        foreach (infl[i]) if (infl[i].epoch == m_epoch) live++;
        exp_req  = !rst_i && !jump_i && (infl.size() < MAX) && (live + ready.size() < DEPTH);
        exp_addr = m_pc;
        obs_req  = imem_req_o;
        obs_addr = imem_addr_o;
        if (rst_i) begin
            m_pc = RPC;
            infl.delete();
            ready.delete();
            m_inst = NOP;
            m_iaddr = '0;
            last_due = 0;
        end else begin
            acc = 1'b0;
            if (imem_rvalid_i) begin
                e = infl.pop_front();
                acc = (e.epoch == m_epoch) && !jump_i;
            end
            if (jump_i) begin
                m_epoch++;
                ready.delete();
                m_pc = {jump_addr_i[31:2], 2'b00};
                m_inst = NOP;
                m_iaddr = '0;
            end else begin
                if (!stall_i) begin
                    if (ready.size() > 0) begin
                        a = ready.pop_front();
                        m_inst = word(a);
                        m_iaddr = a;
                    end else begin
                        m_inst = NOP;
                        m_iaddr = '0;
                    end
                end
                if (acc) ready.push_back(e.addr);
                if (exp_req && imem_gnt_i) begin
                    due = cyc + $urandom_range(lat_min, lat_max);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    infl.push_back('{m_pc, m_epoch, due});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int unsigned n, input logic [31:0] new_key);
        rst_i = 1'b1;
        stall_i = 1'b0;
        jump_i = 1'b0;
        for (int unsigned i = 0; i < n; i++) cycle();
        rst_i = 1'b0;
        key = new_key;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            cycle();
            n_total++;
            if (obs_req !== 1'b0) $display("FAIL reset_req got %b want 0", obs_req);
            else n_pass++;
        end
        n_total++;
        if ({inst_o, inst_addr_o} !== {NOP, 32'h0}) $display("FAIL reset_out got %h/%h want %h/0", inst_o, inst_addr_o, NOP);
        else n_pass++;
        rst_i = 1'b0;
        key = '0;
    endtask

    task automatic test_stream();
        logic [31:0] want_i, want_a;
        gnt_mode = 1; lat_min = 1; lat_max = 1;
        for (int unsigned k = 0; k < 12; k++) begin
            cycle();
            want_a = (k < 2) ? 32'h0 : 32'(4 * (k - 2));
            want_i = (k < 2) ? NOP : want_a;
            n_total++;
            if (obs_req !== 1'b1 || obs_addr !== 32'(4 * k))
                $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, obs_req, obs_addr, 32'(4 * k));
            else n_pass++;
            n_total++;
            if (inst_o !== want_i || inst_addr_o !== want_a)
                $display("FAIL stream_out k=%0d got %h@%h want %h@%h", k, inst_o, inst_addr_o, want_i, want_a);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_i, held_a;
        logic        dropped;
        held_i = inst_o;
        held_a = inst_addr_o;
        dropped = 1'b0;
        stall_i = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            cycle();
            if (!obs_req) dropped = 1'b1;
            n_total++;
            if (inst_o !== held_i || inst_addr_o !== held_a || obs_req !== exp_req)
                $display("FAIL stall_hold k=%0d got %h@%h req %b want %h@%h req %b", k, inst_o, inst_addr_o, obs_req, held_i, held_a, exp_req);
            else n_pass++;
        end
        n_total++;
        if (!dropped) $display("FAIL stall_credit got req held high want a dropped request");
        else n_pass++;
        stall_i = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            cycle();
            n_total++;
            if ({obs_req, obs_addr, inst_o, inst_addr_o} !== {exp_req, exp_addr, m_inst, m_iaddr})
                $display("FAIL stall_resume k=%0d got %b %h %h@%h want %b %h %h@%h", k, obs_req, obs_addr, inst_o, inst_addr_o, exp_req, exp_addr, m_inst, m_iaddr);
            else n_pass++;
        end
    endtask

    task automatic test_gnt_low();
        logic [31:0] a0;
        gnt_mode = 0;
        a0 = imem_addr_o;
        for (int unsigned k = 0; k < 5; k++) begin
            cycle();
            n_total++;
            if (obs_addr !== a0 || inst_o !== m_inst || inst_addr_o !== m_iaddr)
                $display("FAIL gnt_low k=%0d got %h %h@%h want %h %h@%h", k, obs_addr, inst_o, inst_addr_o, a0, m_inst, m_iaddr);
            else n_pass++;
        end
        n_total++;
        if (inst_o !== NOP || inst_addr_o !== 32'h0) $display("FAIL gnt_low_bubble got %h@%h want %h@0", inst_o, inst_addr_o, NOP);
        else n_pass++;
        gnt_mode = 1;
    endtask

    task automatic test_jump(input logic stall_too, input logic [31:0] target);
        logic found;
        apply_reset(1, 32'hC0DE_0000);
        gnt_mode = 1; lat_min = 2; lat_max = 2;
        for (int unsigned k = 0; k < 6; k++) cycle();
        jump_i = 1'b1;
        stall_i = stall_too;
        jump_addr_i = target;
        cycle();
        jump_i = 1'b0;
        stall_i = 1'b0;
        n_total++;
        if (inst_o !== NOP || inst_addr_o !== 32'h0 || obs_req !== 1'b0)
            $display("FAIL jump_flush got %h@%h req %b want %h@0 req 0", inst_o, inst_addr_o, obs_req, NOP);
        else n_pass++;
        found = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) begin
                n_total++;
                if (obs_req !== 1'b1 || obs_addr !== {target[31:2], 2'b00})
                    $display("FAIL jump_first_req got %b/%h want 1/%h", obs_req, obs_addr, {target[31:2], 2'b00});
                else n_pass++;
            end
            n_total++;
            if (inst_o !== m_inst || inst_addr_o !== m_iaddr)
                $display("FAIL jump_path k=%0d got %h@%h want %h@%h", k, inst_o, inst_addr_o, m_inst, m_iaddr);
            else n_pass++;
            if (!found && inst_o !== NOP) begin
                found = 1'b1;
                n_total++;
                if (inst_addr_o !== {target[31:2], 2'b00} || inst_o !== word({target[31:2], 2'b00}))
                    $display("FAIL jump_first_inst got %h@%h want %h@%h", inst_o, inst_addr_o, word({target[31:2], 2'b00}), {target[31:2], 2'b00});
                else n_pass++;
            end
        end
        n_total++;
        if (!found) $display("FAIL jump_timeout got no instruction want one within 10 cycles");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        gnt_mode = 1; lat_min = 1; lat_max = 1;
        for (int unsigned k = 0; k < 6; k++) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        n_total++;
        if (obs_req !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0)
            $display("FAIL reset_mid got req %b %h@%h want req 0 %h@0", obs_req, inst_o, inst_addr_o, NOP);
        else n_pass++;
        cycle();
        n_total++;
        if (obs_req !== 1'b1 || obs_addr !== RPC)
            $display("FAIL reset_restart got %b/%h want 1/%h", obs_req, obs_addr, RPC);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset(1, 32'h5A5A_A5A4);
        gnt_mode = 2; lat_min = 1; lat_max = 3;
        for (int unsigned k = 0; k < 3000; k++) begin
            rst_i   = ($urandom_range(0, 199) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            jump_i  = ($urandom_range(0, 19) == 0);
            jump_addr_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle();
            n_total++;
            if ((!rst_i && {obs_req, obs_addr} !== {exp_req, exp_addr}) || (rst_i && obs_req !== 1'b0) ||
                {inst_o, inst_addr_o} !== {m_inst, m_iaddr})
                $display("FAIL random k=%0d got %b %h %h@%h want %b %h %h@%h", k, obs_req, obs_addr, inst_o, inst_addr_o, exp_req, exp_addr, m_inst, m_iaddr);
            else n_pass++;
        end
        rst_i = 1'b0;
        stall_i = 1'b0;
        jump_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_low();
        test_jump(1'b0, 32'h0000_0100);
        test_jump(1'b1, 32'h0000_0203);
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
